pixel_stream_reader: RTL
========================

PIXEL_STREAM_READER -- requirements
Module: pixel_stream_reader

Interface
REQ-001 SHALL have parameter IMG_W, default 150, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 150, image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 17, BRAM address width.
REQ-004 SHALL have parameter DATA_W, default 8, pixel width.
REQ-005 SHALL have parameter RD_LAT, default 2, BRAM read latency in clocks.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >= RD_LAT+1).
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 start  input  1  one-cycle request to stream the full frame.
REQ-010 busy  output  1  high from start acceptance until done pulse.
REQ-011 done  output  1  one-cycle pulse after final pixel handshake.
REQ-012 bram_en, bram_ren, bram_wen  output  1 each  BRAM controls; bram_wen is tied to 0.
REQ-013 bram_addr  output  ADDR_W  BRAM read address.
REQ-014 bram_dout  input  DATA_W  BRAM read data.
REQ-015 pix_data  output  DATA_W  streamed pixel.
REQ-016 pix_valid  output  1  pix_data/pix_row/pix_col/pix_last valid.
REQ-017 pix_ready  input  1  downstream accepts when pix_valid & pix_ready at rising edge.
REQ-018 pix_row, pix_col  output  8 each  coordinates of the current pixel.
REQ-019 pix_last  output  1  current pixel is address IMG_W*IMG_H-1.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start, RUN->DRAIN after last address issued, DRAIN->IDLE on last pixel handshake (done pulses that cycle's following edge).
REQ-021 start while busy SHALL be ignored.
REQ-022 Reads SHALL be issued in raster order, addresses 0 to IMG_W*IMG_H-1, one per cycle max.
REQ-023 An issue cycle SHALL drive bram_en=1, bram_ren=1, bram_addr=A; non-issue cycles drive bram_en=0, bram_ren=0, bram_addr holds.
REQ-024 Data for an issue at edge N SHALL be captured from bram_dout at edge N+RD_LAT into the FIFO, tracked by an RD_LAT-deep valid shift register.
REQ-025 Issue SHALL occur only when in-flight reads + FIFO occupancy < FIFO_DEPTH; FIFO never overflows.
REQ-026 pix_valid SHALL equal FIFO non-empty; pix_data shows the FIFO head; pop on handshake.
REQ-027 Simultaneous capture and pop SHALL keep occupancy unchanged; capture into an empty FIFO SHALL appear on pix_valid the next cycle.
REQ-028 With pix_ready held high, sustained throughput SHALL be one pixel per cycle; first pix_valid RD_LAT+1 cycles after start.
REQ-029 pix_col SHALL increment per handshake and wrap IMG_W-1->0 with pix_row increment; pix_last=1 only at row IMG_H-1, col IMG_W-1.
REQ-030 pix_valid low SHALL leave pix_data and coordinates stable; pix_valid high with pix_ready low SHALL hold all pixel outputs stable.
REQ-031 Address counter SHALL not exceed IMG_W*IMG_H-1; no wrap to 0 within a frame.

Reset
REQ-032 rst asserted SHALL immediately force: state IDLE, busy=0, done=0, bram_en=0, bram_ren=0, bram_wen=0, bram_addr=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, pix_last=0, FIFO and in-flight tracking emptied.
REQ-033 rst mid-frame SHALL discard in-flight reads; data returning after rst release SHALL not be captured.
REQ-034 After rst release, block SHALL wait for a new start.

Verification
REQ-035 BRAM model (RD_LAT=2) with mem[a]=a[7:0], pix_ready=1, start -> 22500 pixels, pix_data=k mod 256 in order, first pix_valid 3 cycles after start, done once after pix_last.
REQ-036 pix_ready toggling 1/0 every cycle -> no lost or duplicated pixel, outputs stable while stalled, issue stops once 4 credits used.
REQ-037 pix_ready=0 for 50 cycles after start -> exactly 4 reads issued, FIFO full, bram_en low until pop.
REQ-038 Check boundaries: handshake at address 149 -> pix_row=0,pix_col=149; address 150 -> pix_row=1,pix_col=0; address 22499 -> pix_last=1,row=149,col=149.
REQ-039 rst asserted at pixel 1000 then new start -> outputs zero during rst, stream restarts at address 0 with no stale data.
REQ-040 start pulsed while busy -> ignored, frame count and done pulses unchanged.

Source files
------------

// File: rtl/pixel_stream_reader_if.sv
// Pixel stream reader bus bundle: frame control, BRAM read port and pixel stream.
//   master : the reader (drives busy/done, BRAM controls, pixel outputs)
//   slave  : the environment (drives start, bram_dout, pix_ready)
interface pixel_stream_reader_if #(
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned DATA_W = 8
);
   logic              start;
   logic              busy;
   logic              done;
   logic              bram_en;
   logic              bram_ren;
   logic              bram_wen;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_dout;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic [7:0]        pix_row;
   logic [7:0]        pix_col;
   logic              pix_last;

   modport master (
      input  start, bram_dout, pix_ready,
      output busy, done, bram_en, bram_ren, bram_wen, bram_addr,
             pix_data, pix_valid, pix_row, pix_col, pix_last
   );

   modport slave (
      output start, bram_dout, pix_ready,
      input  busy, done, bram_en, bram_ren, bram_wen, bram_addr,
             pix_data, pix_valid, pix_row, pix_col, pix_last
   );
endinterface

// File: rtl/pixel_stream_reader.sv
// Streams a full IMG_W x IMG_H frame out of a BRAM in raster order.
// Reads are credit-limited so that in-flight reads plus buffered pixels never
// exceed FIFO_DEPTH; returned data lands in a small FIFO whose head drives the
// valid/ready pixel stream together with its row/column coordinates.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : start/busy/done, BRAM read port, pixel stream (see interface)
module pixel_stream_reader #(
   parameter int unsigned IMG_W      = 150,
   parameter int unsigned IMG_H      = 150,
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   pixel_stream_reader_if.master bus
);
   localparam int unsigned TOTAL = IMG_W * IMG_H;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
   localparam logic [7:0]        LAST_COL  = 8'(IMG_W - 1);
   localparam logic [7:0]        LAST_ROW  = 8'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_q, state_n;
   logic [RD_LAT-1:0] vld_q, vld_n;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;

   logic              busy_q, busy_n, done_q, done_n, en_q, en_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] data_q, data_n;
   logic              valid_q, valid_n, last_q, last_n;
   logic [7:0]        row_q, row_n, col_q, col_n;

   logic              issue_c, capture_c, pop_c, credit_ok_c;
   logic [ADDR_W-1:0] issue_addr_c;
   logic [SUM_W-1:0]  inflight_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_n;
   end

   // Next state and read issue; the first read goes out on the start edge
   always_comb begin
      state_n      = state_q;
      issue_c      = 1'b0;
      issue_addr_c = addr_q + ADDR_W'(1);
      capture_c    = vld_q[RD_LAT-1];
      pop_c        = valid_q & bus.pix_ready;
      inflight_c   = '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         inflight_c = inflight_c + SUM_W'(vld_q[i]);
      end
      credit_ok_c = (inflight_c + SUM_W'(cnt_q)) < SUM_W'(FIFO_DEPTH);

      unique case (state_q)
         IDLE: begin
            // FIFO and read pipeline are always empty here, so no credit check
            if (bus.start) begin
               issue_c      = 1'b1;
               issue_addr_c = '0;
               state_n      = (TOTAL == 1) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (credit_ok_c) begin
               issue_c = 1'b1;
               if (issue_addr_c == LAST_ADDR) state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (pop_c && last_q) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath next values: read pipeline, FIFO pointers, registered outputs
   always_comb begin
      vld_n    = (vld_q << 1) | RD_LAT'(issue_c);
      wr_ptr_n = capture_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_n = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_n    = cnt_q + CNT_W'(capture_c) - CNT_W'(pop_c);

      // Head register tracks the entry that will sit at rd_ptr after this edge
      data_n = data_q;
      if (pop_c) begin
         if (cnt_q > CNT_W'(1))  data_n = mem_q[rd_ptr_q + PTR_W'(1)];
         else if (capture_c)     data_n = bus.bram_dout;
      end else if ((cnt_q == '0) && capture_c) begin
         data_n = bus.bram_dout;
      end
      valid_n = (cnt_n != '0);

      row_n = row_q;
      col_n = col_q;
      if (pop_c) begin
         if (col_q == LAST_COL) begin
            col_n = '0;
            row_n = (row_q == LAST_ROW) ? 8'd0 : row_q + 8'd1;
         end else begin
            col_n = col_q + 8'd1;
         end
      end
      last_n = (row_n == LAST_ROW) && (col_n == LAST_COL);

      done_n = pop_c & last_q;
      busy_n = (state_n != IDLE);
      en_n   = issue_c;
      addr_n = issue_c ? issue_addr_c : addr_q;
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         en_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         last_q   <= 1'b0;
      end else begin
         vld_q    <= vld_n;
         wr_ptr_q <= wr_ptr_n;
         rd_ptr_q <= rd_ptr_n;
         cnt_q    <= cnt_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         en_q     <= en_n;
         addr_q   <= addr_n;
         data_q   <= data_n;
         valid_q  <= valid_n;
         row_q    <= row_n;
         col_q    <= col_n;
         last_q   <= last_n;
      end
   end

   // FIFO storage; writes are gated by the reset-cleared read pipeline
   always_ff @(posedge clk) begin
      if (capture_c) mem_q[wr_ptr_q] <= bus.bram_dout;
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.bram_en   = en_q;
   assign bus.bram_ren  = en_q;
   assign bus.bram_wen  = 1'b0;
   assign bus.bram_addr = addr_q;
   assign bus.pix_data  = data_q;
   assign bus.pix_valid = valid_q;
   assign bus.pix_row   = row_q;
   assign bus.pix_col   = col_q;
   assign bus.pix_last  = last_q;
endmodule
